led_cmd_sched: RTL and testbench

- Command scheduler between the HPS bridge byte port (write / writedata exports) and the LED blinker.
- Merges HPS command bytes and one-shot KEY pulses (faster/slower) into a single ordered stream.
- Decodes each command and drives the blinker's delay, mode and pause controls.
- Enforces a hold-off after every applied command so the blinker sees stable settings.

---
 rtl/led_cmd_pkg.sv | 31 +++
 rtl/led_cmd_sched_fifo.sv | 55 +++++
 rtl/led_cmd_sched.sv | 164 ++++++++++++++++
 tb/tb_led_cmd_sched.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_cmd_pkg.sv
// Shared definitions for the LED command scheduler: opcodes, FSM states and
// the delay clamp helper.
package led_cmd_pkg;

    localparam logic [1:0] OP_SET_DELAY = 2'b00;
    localparam logic [1:0] OP_STEP      = 2'b01;
    localparam logic [1:0] OP_SET_MODE  = 2'b10;
    localparam logic [1:0] OP_PAUSE     = 2'b11;

    // Key pulses are turned into STEP bytes: bit 0 set means shorter delay.
    localparam logic [7:0] KEY_CMD_FASTER = 8'h41;
    localparam logic [7:0] KEY_CMD_SLOWER = 8'h40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic logic [3:0] clamp(input logic [3:0] v,
                                         input logic [3:0] lo,
                                         input logic [3:0] hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/led_cmd_sched_fifo.sv
// Small synchronous FIFO for HPS command bytes; pop on empty is ignored and a
// push on full is only accepted when a pop frees a slot in the same cycle.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/led_cmd_sched.sv
// Merges HPS command bytes and KEY pulses into one stream and drives the blinker.
// Define LED_CMD_SCHED_STATUS_EN to add the registered status readback port.
module led_cmd_sched
    import led_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLDOFF     = 16,
    parameter int DELAY_RESET = 8,
    parameter int DELAY_MIN   = 1,
    parameter int DELAY_MAX   = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hps_write,
    input  logic [7:0] hps_writedata,
    input  logic       key_faster,
    input  logic       key_slower,
    output logic [3:0] delay,
    output logic [1:0] mode,
    output logic       pause,
    output logic       cmd_applied,
    output logic       overflow
`ifdef LED_CMD_SCHED_STATUS_EN
    ,
    output logic [7:0] status
`endif
);

    localparam int         HW    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [3:0] D_MIN = 4'(DELAY_MIN);
    localparam logic [3:0] D_MAX = 4'(DELAY_MAX);

    state_t        state, state_next;
    logic [7:0]    cmd_r, cmd_next;
    logic [HW-1:0] hold_cnt, hold_cnt_next;
    logic          prio_hps;
    logic          kf_pend, ks_pend;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic          key_clr, grant, grant_hps, apply;
    logic [3:0]    delay_next;
    logic [1:0]    mode_next;
    logic          pause_next;
    logic          unused_cmd_bits;

    assign unused_cmd_bits = ^cmd_r[5:4];

    cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (hps_write),
        .pop   (fifo_pop),
        .din   (hps_writedata),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Round-robin grant in IDLE; both keys pending cancel each other out.
    always_comb begin
        state_next    = state;
        cmd_next      = cmd_r;
        hold_cnt_next = hold_cnt;
        fifo_pop      = 1'b0;
        key_clr       = 1'b0;
        grant         = 1'b0;
        grant_hps     = 1'b0;
        apply         = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && (prio_hps || !(kf_pend || ks_pend))) begin
                    fifo_pop   = 1'b1;
                    grant      = 1'b1;
                    grant_hps  = 1'b1;
                    cmd_next   = fifo_dout;
                    state_next = APPLY;
                end else if (kf_pend || ks_pend) begin
                    key_clr = 1'b1;
                    grant   = 1'b1;
                    if (!(kf_pend && ks_pend)) begin
                        cmd_next   = kf_pend ? KEY_CMD_FASTER : KEY_CMD_SLOWER;
                        state_next = APPLY;
                    end
                end
            end
            APPLY: begin
                apply         = 1'b1;
                hold_cnt_next = '0;
                state_next    = (HOLDOFF > 0) ? HOLD : IDLE;
            end
            HOLD: begin
                if (hold_cnt == HW'(HOLDOFF - 1))
                    state_next = IDLE;
                else
                    hold_cnt_next = hold_cnt + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        delay_next = delay;
        mode_next  = mode;
        pause_next = pause;
        if (apply) begin
            case (cmd_r[7:6])
                OP_SET_DELAY: delay_next = clamp(cmd_r[3:0], D_MIN, D_MAX);
                OP_STEP: begin
                    if (cmd_r[0])
                        delay_next = (delay > D_MIN) ? delay - 1'b1 : D_MIN;
                    else
                        delay_next = (delay < D_MAX) ? delay + 1'b1 : D_MAX;
                end
                OP_SET_MODE:  mode_next  = cmd_r[1:0];
                OP_PAUSE:     pause_next = cmd_r[0];
                default:      ;
            endcase
        end
    end

    // A key pulse arriving in the grant cycle survives as a fresh request.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_r       <= '0;
            hold_cnt    <= '0;
            prio_hps    <= 1'b1;
            kf_pend     <= 1'b0;
            ks_pend     <= 1'b0;
            overflow    <= 1'b0;
            delay       <= 4'(DELAY_RESET);
            mode        <= '0;
            pause       <= 1'b0;
            cmd_applied <= 1'b0;
        end else begin
            cmd_r       <= cmd_next;
            hold_cnt    <= hold_cnt_next;
            prio_hps    <= grant ? !grant_hps : prio_hps;
            kf_pend     <= (kf_pend && !key_clr) || key_faster;
            ks_pend     <= (ks_pend && !key_clr) || key_slower;
            overflow    <= overflow || (hps_write && fifo_full && !fifo_pop);
            delay       <= delay_next;
            mode        <= mode_next;
            pause       <= pause_next;
            cmd_applied <= apply;
        end
    end

`ifdef LED_CMD_SCHED_STATUS_EN
    always_ff @(posedge clk) begin
        if (reset)
            status <= 8'h20;
        else
            status <= {overflow, fifo_full, fifo_empty, kf_pend, ks_pend, state, 1'b0};
    end
`endif

endmodule

// File: tb/tb_led_cmd_sched.sv
// Scoreboard bench for led_cmd_sched: stimulus queues expected blinker settings,
// a monitor pops and compares them on every cmd_applied pulse.
module tb_led_cmd_sched;

    localparam int HOLDOFF = 16;
    localparam int SPACING = 2 + HOLDOFF;

    logic       clk = 1'b0;
    logic       reset;
    logic       hps_write;
    logic [7:0] hps_writedata;
    logic       key_faster;
    logic       key_slower;
    logic [3:0] delay;
    logic [1:0] mode;
    logic       pause;
    logic       cmd_applied;
    logic       overflow;
`ifdef LED_CMD_SCHED_STATUS_EN
    logic [7:0] status;
`endif

    led_cmd_sched #(
        .FIFO_DEPTH  (4),
        .HOLDOFF     (HOLDOFF),
        .DELAY_RESET (8),
        .DELAY_MIN   (1),
        .DELAY_MAX   (15)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .hps_write     (hps_write),
        .hps_writedata (hps_writedata),
        .key_faster    (key_faster),
        .key_slower    (key_slower),
        .delay         (delay),
        .mode          (mode),
        .pause         (pause),
        .cmd_applied   (cmd_applied),
        .overflow      (overflow)
`ifdef LED_CMD_SCHED_STATUS_EN
        ,
        .status        (status)
`endif
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cycle = 0;
    logic [6:0] exp_q[$];
    int         pulse_times[$];

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: every applied command must match the oldest queued expectation.
    initial begin
        logic [6:0] e;
        forever begin
            @(negedge clk);
            if (cmd_applied) begin
                pulse_times.push_back(cycle);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_apply got d=%0d m=%0d p=%0d required no pulse",
                             delay, mode, pause);
                end else begin
                    e = exp_q.pop_front();
                    if ({delay, mode, pause} !== e) begin
                        errors++;
                        $display("[TB] FAIL applied_cmd got d=%0d m=%0d p=%0d required d=%0d m=%0d p=%0d",
                                 delay, mode, pause, e[6:3], e[2:1], e[0]);
                    end
                end
            end
        end
    end

    task automatic check_output(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s got %0d required %0d", name, actual, required);
        end
    endtask

    task automatic expect_cmd(input logic [3:0] d, input logic [1:0] m, input logic p);
        exp_q.push_back({d, m, p});
    endtask

    task automatic apply_stimulus(input logic [7:0] b);
        @(negedge clk);
        hps_write     = 1'b1;
        hps_writedata = b;
        @(negedge clk);
        hps_write     = 1'b0;
    endtask

    task automatic key_pulse(input logic f, input logic s);
        @(negedge clk);
        key_faster = f;
        key_slower = s;
        @(negedge clk);
        key_faster = 1'b0;
        key_slower = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n0;
        int pulses;
        reset         = 1'b1;
        hps_write     = 1'b0;
        hps_writedata = '0;
        key_faster    = 1'b0;
        key_slower    = 1'b0;
        idle_cycles(3);
        reset = 1'b0;

        // Reset release
        idle_cycles(1);
        check_output("reset_delay", delay, 8);
        check_output("reset_mode", mode, 0);
        check_output("reset_pause", pause, 0);
        check_output("reset_overflow", overflow, 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_applied) pulses++;
        end
        check_output("reset_quiet_pulses", pulses, 0);

        // First-command latency: sampled at E0, applied after E2
        expect_cmd(4'd5, 2'd0, 1'b0);
        apply_stimulus(8'h05);
        @(negedge clk);
        check_output("latency_e1_applied", cmd_applied, 0);
        @(negedge clk);
        check_output("latency_e2_applied", cmd_applied, 1);
        check_output("latency_e2_delay", delay, 5);
        idle_cycles(SPACING + 2);

        expect_cmd(4'd15, 2'd0, 1'b0);
        apply_stimulus(8'h0F);
        idle_cycles(SPACING + 4);
        expect_cmd(4'd1, 2'd0, 1'b0);
        apply_stimulus(8'h00);
        idle_cycles(SPACING + 4);

        // Ordered burst with hold-off spacing
        n0 = pulse_times.size();
        expect_cmd(4'd3, 2'd0, 1'b0);
        expect_cmd(4'd3, 2'd2, 1'b0);
        expect_cmd(4'd3, 2'd2, 1'b1);
        @(negedge clk);
        hps_write = 1'b1;
        hps_writedata = 8'h03;
        @(negedge clk);
        hps_writedata = 8'h82;
        @(negedge clk);
        hps_writedata = 8'hC1;
        @(negedge clk);
        hps_write = 1'b0;
        idle_cycles(3 * SPACING + 6);
        check_output("burst_pulse_count", pulse_times.size() - n0, 3);
        if (pulse_times.size() - n0 == 3) begin
            check_output("burst_spacing_1", pulse_times[n0+1] - pulse_times[n0], SPACING);
            check_output("burst_spacing_2", pulse_times[n0+2] - pulse_times[n0+1], SPACING);
        end

        // Saturation at both bounds
        expect_cmd(4'd1, 2'd2, 1'b1);
        apply_stimulus(8'h01);
        idle_cycles(SPACING + 4);
        expect_cmd(4'd1, 2'd2, 1'b1);
        key_pulse(1'b1, 1'b0);
        idle_cycles(SPACING + 4);
        expect_cmd(4'd15, 2'd2, 1'b1);
        apply_stimulus(8'h0F);
        idle_cycles(SPACING + 4);
        expect_cmd(4'd15, 2'd2, 1'b1);
        apply_stimulus(8'h40);
        idle_cycles(SPACING + 4);

        // Both keys together cancel; a later single key must act on its own
        n0 = pulse_times.size();
        key_pulse(1'b1, 1'b1);
        idle_cycles(SPACING + 4);
        check_output("both_keys_pulses", pulse_times.size() - n0, 0);
        check_output("both_keys_delay", delay, 15);
        expect_cmd(4'd14, 2'd2, 1'b1);
        key_pulse(1'b1, 1'b0);
        idle_cycles(SPACING + 4);

        // Overflow: six writes during HOLD into a four-entry FIFO
        expect_cmd(4'd2, 2'd2, 1'b1);
        apply_stimulus(8'h02);
        idle_cycles(3);
        check_output("pre_overflow", overflow, 0);
        expect_cmd(4'd3, 2'd2, 1'b1);
        expect_cmd(4'd4, 2'd2, 1'b1);
        expect_cmd(4'd5, 2'd2, 1'b1);
        expect_cmd(4'd6, 2'd2, 1'b1);
        @(negedge clk);
        hps_write = 1'b1;
        for (int i = 0; i < 6; i++) begin
            hps_writedata = 8'(3 + i);
            @(negedge clk);
        end
        hps_write = 1'b0;
        check_output("overflow_set", overflow, 1);
        idle_cycles(5 * SPACING + 6);
        check_output("overflow_sticky", overflow, 1);
        check_output("final_delay", delay, 6);
        check_output("scoreboard_drained", exp_q.size(), 0);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("post_reset_overflow", overflow, 0);
        check_output("post_reset_delay", delay, 8);
        check_output("post_reset_mode", mode, 0);
        check_output("post_reset_pause", pause, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
